// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions used by fetch, decode and the immediate generator:
// widths, reset vector, canonical NOP, base opcodes, fetch FSM states and the buffered fetch entry.
package rv32_pkg;
    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        FS_RUN   = 2'd0,
        FS_DRAIN = 2'd1,
        FS_TRAP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] p);
        return p + 32'd4;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH x WIDTH circular FIFO with synchronous flush (flush beats push/pop).
// Latency: a push is visible at the head the next cycle; head is read straight from registers.
// Backpressure: none internally; the caller's credit accounting keeps it from overflowing.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push    = push_i && !flush_i;
    assign do_pop     = pop_i && !flush_i && (count_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, in-order imem word requests, {pc,instr} buffer towards decode; build option FETCH_MISALIGN_TRAP_EN.
// Latency: response in cycle N is offered to decode in N+1; a redirect's first request goes out the cycle after it.
// Backpressure: id_ready low holds the head; requests stop once buffered + in-flight words reach FIFO_DEPTH.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_misaligned
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   drop_cnt_q;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credits_used;
    logic [CW-1:0]   redir_drop;
    logic [XLEN-1:0] redir_pc;
    logic            redir_trap;
    logic            rsp_ok;
    logic            req_fire;
    logic            push;
    logic            pop;
    fetch_entry_t    push_ent;
    fetch_entry_t    head;

    // A response with nothing in flight is a memory-side protocol error; it is ignored.
    assign rsp_ok       = imem_rsp_valid && (outstanding_q != '0);
    assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req_valid = rst_n && (credits_used < (CW+1)'(FIFO_DEPTH))
                            && !redirect_valid && (state_q != FS_TRAP);
    assign imem_req_addr = fetch_pc_q;
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign redir_drop    = outstanding_q - CW'(rsp_ok);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_pc         = redirect_pc;
    assign redir_trap       = (redirect_pc[1:0] != 2'b00);
    assign fetch_misaligned = (state_q == FS_TRAP);
`else
    assign redir_pc   = redirect_pc & ~32'h3;
    assign redir_trap = 1'b0;
`endif

    assign push     = rsp_ok && (drop_cnt_q == '0) && (state_q != FS_TRAP) && !redirect_valid;
    assign pop      = id_valid && id_ready;
    assign push_ent = '{pc: rsp_pc_q, instr: imem_rsp_data};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .flush_i    (redirect_valid),
        .head_dat_o (head),
        .count_o    (fifo_count)
    );

    assign id_valid    = (fifo_count != '0) && (state_q != FS_TRAP);
    assign instruction = id_valid ? head.instr : NOP_INSTR;
    // While trapped, fetch_pc_q still holds the offending redirect target.
    assign pc          = (state_q == FS_TRAP) ? fetch_pc_q : (id_valid ? head.pc : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= FS_RUN;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_q + CW'(req_fire) - CW'(rsp_ok);
            if (redirect_valid) begin
                fetch_pc_q <= redir_pc;
                rsp_pc_q   <= redir_pc;
                drop_cnt_q <= redir_drop;
                if (redir_trap)              state_q <= FS_TRAP;
                else if (redir_drop != '0)   state_q <= FS_DRAIN;
                else                         state_q <= FS_RUN;
            end else begin
                if (req_fire) fetch_pc_q <= pc_next(fetch_pc_q);
                if (rsp_ok && (drop_cnt_q != '0)) begin
                    drop_cnt_q <= drop_cnt_q - CW'(1);
                    if ((drop_cnt_q == CW'(1)) && (state_q == FS_DRAIN)) state_q <= FS_RUN;
                end else if (push) begin
                    rsp_pc_q <= pc_next(rsp_pc_q);
                end
            end
        end
    end

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (outstanding_q == '0)));
endmodule

// File: tb/tb_fetch_unit.sv
// Random + directed bench for fetch_unit against a program-order stream model and a latency-queue memory.
module tb_fetch_unit;
    import rv32_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        redirect_valid, id_valid, id_ready;
    logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, instruction, pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .instruction    (instruction),
        .pc             (pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       mq[$];
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0, buf_n = 0, epoch = 0, last_due = 0;
    int          n_fire = 0, n_deliv = 0;
    int          mem_rdy_pct, id_rdy_pct, lat_lo, lat_hi;
    logic [31:0] exp_pc, exp_addr, trap_pc, redir_tgt, last_fire_addr, s_pc;
    bit          trap_m, redir_pend, s_idv;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock cycle: drive inputs, check outputs against the stream model, advance the model.
    task automatic step();
        bit    rsp_now, rsp_live, popn, exp_rv;
        int    due;
        mreq_t r;
        imem_req_ready = ($urandom_range(99) < mem_rdy_pct);
        id_ready       = ($urandom_range(99) < id_rdy_pct);
        redirect_valid = redir_pend;
        redirect_pc    = redir_pend ? redir_tgt : $urandom();
        rsp_now  = 1'b0;
        rsp_live = 1'b0;
        imem_rsp_data = $urandom();
        if (mq.size() != 0) begin
            if (mq[0].due <= cyc) begin
                rsp_now       = 1'b1;
                rsp_live      = (mq[0].epoch == epoch);
                imem_rsp_data = word(mq[0].addr);
            end
        end
        imem_rsp_valid = rsp_now;
        #2;
        exp_rv = (buf_n + mq.size() < DEPTH) && !redir_pend && !trap_m;
        check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (imem_req_valid && exp_rv) check_eq("req_addr", imem_req_addr, exp_addr);
        check_eq("id_valid", 32'(id_valid), 32'(buf_n != 0));
        if (buf_n != 0) begin
            check_eq("head_pc", pc, exp_pc);
            check_eq("head_instr", instruction, word(exp_pc));
        end else begin
            check_eq("empty_instr", instruction, NOP_INSTR);
            check_eq("empty_pc", pc, trap_m ? trap_pc : 32'h0);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("misaligned", 32'(fetch_misaligned), 32'(trap_m));
`endif
        s_idv = id_valid;
        s_pc  = pc;
        popn = (buf_n != 0) && id_ready && !redir_pend;
        if (popn) begin
            buf_n--;
            exp_pc += 32'd4;
            n_deliv++;
        end
        if (rsp_now) begin
            if (rsp_live && !redir_pend) buf_n++;
            void'(mq.pop_front());
        end
        if (exp_rv && imem_req_ready) begin
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.addr = exp_addr; r.due = due; r.epoch = epoch;
            mq.push_back(r);
            n_fire++;
            last_fire_addr = imem_req_addr;
            exp_addr += 32'd4;
        end
        if (redir_pend) begin
            epoch++;
            buf_n = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_m  = (redir_tgt[1:0] != 2'b00);
            trap_pc = redir_tgt;
            exp_pc  = redir_tgt;
`else
            trap_m  = 1'b0;
            exp_pc  = {redir_tgt[31:2], 2'b00};
`endif
            exp_addr   = exp_pc;
            redir_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        mq.delete();
        buf_n = 0; epoch++; exp_pc = '0; exp_addr = '0;
        trap_m = 1'b0; trap_pc = '0; redir_pend = 1'b0; last_due = cyc;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check_eq("rst_id_valid", 32'(id_valid), 32'h0);
        check_eq("rst_instr", instruction, NOP_INSTR);
        check_eq("rst_pc", pc, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redir_pend = 1'b1;
        redir_tgt  = tgt;
        step();
    endtask

    task automatic wait_deliv(input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            step();
            if (s_idv) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first, nf0, nd0;
        bit ok, found;
        rst_n = 1'b0;

        // Back-to-back fetch with single-cycle memory.
        mem_rdy_pct = 100; id_rdy_pct = 100; lat_lo = 1; lat_hi = 1;
        do_reset();
        first = -1; nd0 = n_deliv;
        for (int k = 0; k < 30; k++) begin
            step();
            if (first < 0 && s_idv) first = k;
        end
        check_eq("first_idv_cycle", first, 2);
        check_eq("p1_progress", 32'(n_deliv - nd0 >= 15), 32'h1);

        // Decode stalled: buffer fills to DEPTH, then fetch stops with the head held.
        do_reset();
        id_rdy_pct = 0; nf0 = n_fire;
        repeat (10) step();
        check_eq("bp_req_count", n_fire - nf0, DEPTH);
        check_eq("bp_head_valid", 32'(s_idv), 32'h1);
        check_eq("bp_head_pc", s_pc, 32'h0);
        id_rdy_pct = 100; nd0 = n_deliv;
        repeat (10) step();
        check_eq("bp_resume", 32'(n_deliv - nd0 >= 4), 32'h1);

        // Redirect with two requests in flight on 3-cycle memory.
        do_reset();
        lat_lo = 3; lat_hi = 3;
        for (int k = 0; k < 50 && mq.size() != 2; k++) step();
        redirect_to(32'h0000_0100);
        wait_deliv(50, ok);
        check_eq("redir_deliv", 32'(ok), 32'h1);
        check_eq("redir_first_pc", s_pc, 32'h0000_0100);

        // Redirect colliding with a response and a pop in the same cycle.
        lat_lo = 1; lat_hi = 2;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (buf_n != 0 && mq.size() != 0) begin
                if (mq[0].due <= cyc) begin
                    found = 1'b1;
                    break;
                end
            end
            step();
        end
        check_eq("collide_setup", 32'(found), 32'h1);
        redirect_to(32'h0000_0400);
        check_eq("collide_flushed", 32'(id_valid), 32'h0);
        wait_deliv(50, ok);
        check_eq("collide_deliv", 32'(ok), 32'h1);
        check_eq("collide_first_pc", s_pc, 32'h0000_0400);

        // PC wrap at the top of the address space.
        lat_lo = 1; lat_hi = 1;
        redirect_to(32'hFFFF_FFFC);
        nf0 = n_fire;
        for (int k = 0; k < 50 && n_fire - nf0 < 2; k++) step();
        check_eq("wrap_req_count", n_fire - nf0, 2);
        check_eq("wrap_addr", last_fire_addr, 32'h0000_0000);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect parks fetch until an aligned redirect.
        redirect_to(32'h0000_0102);
        repeat (5) step();
        check_eq("trap_flag", 32'(fetch_misaligned), 32'h1);
        check_eq("trap_noreq", 32'(imem_req_valid), 32'h0);
        check_eq("trap_pc", pc, 32'h0000_0102);
        redirect_to(32'h0000_0200);
        wait_deliv(50, ok);
        check_eq("trap_exit_deliv", 32'(ok), 32'h1);
        check_eq("trap_exit_pc", s_pc, 32'h0000_0200);
        check_eq("trap_exit_flag", 32'(fetch_misaligned), 32'h0);
`endif

        // Random traffic with redirects, variable latency and one mid-run reset.
        mem_rdy_pct = 70; id_rdy_pct = 60; lat_lo = 1; lat_hi = 4;
        nd0 = n_deliv;
        for (int k = 0; k < 4000; k++) begin
            if (k == 2000) do_reset();
            if ($urandom_range(99) < 3) begin
                logic [31:0] t;
                t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4)
                                             : ($urandom() & 32'hFFFF_FFFC);
                if ($urandom_range(7) == 0) t[1:0] = 2'($urandom_range(3, 1));
                redir_pend = 1'b1;
                redir_tgt  = t;
            end
            step();
        end
        check_eq("rand_progress", 32'(n_deliv - nd0 > 100), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
